// File: rtl/id_exe_stage_pkg.sv
// Shared definitions for the ID/EXE pipeline stage: branch and ALU command
// encodings, the decoded control bundle, its bubble value and width defaults.
package id_exe_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_MOV = 4'd1,
    CMD_ADD = 4'd2,
    CMD_SUB = 4'd4,
    CMD_AND = 4'd6,
    CMD_OR  = 4'd7,
    CMD_XOR = 4'd8,
    CMD_MVN = 4'd9,
    CMD_SHL = 4'd10,
    CMD_SHR = 4'd11
  } exe_cmd_e;

  typedef struct packed {
    logic       is_immediate;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic [3:0] exe_cmd;
    logic [1:0] br_type;
  } ctrl_t;

  // A bubble has no side effects: no writeback, no memory access, no branch.
  localparam ctrl_t CTRL_BUBBLE = '{
    is_immediate: 1'b0,
    mem_r_en:     1'b0,
    mem_w_en:     1'b0,
    wb_en:        1'b0,
    exe_cmd:      CMD_NOP,
    br_type:      BR_NONE
  };

endpackage

// File: rtl/id_exe_stage_hazard_detect.sv
// Read-after-write hazard check of the ID instruction's sources against the
// destinations still in flight. FORWARDING_EN limits the check to load-use in EXE.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             check_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic exe_hit_en;
  logic mem_hit_en;

  function automatic logic src_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dest,
                                   input logic             en);
    return en && (src != '0) && (src == dest);
  endfunction

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; everything else bypasses.
  assign exe_hit_en = exe_wb_en & exe_mem_r_en;
  assign mem_hit_en = 1'b0;
`else
  logic unused_mem_r_en;
  assign unused_mem_r_en = exe_mem_r_en;
  assign exe_hit_en = exe_wb_en;
  assign mem_hit_en = mem_wb_en;
`endif

  assign hazard = src_hit(src1, exe_dest, exe_hit_en)
               || src_hit(src1, mem_dest, mem_hit_en)
               || (check_src2 && (src_hit(src2, exe_dest, exe_hit_en)
                               || src_hit(src2, mem_dest, mem_hit_en)));

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with branch resolution and hazard stall generation.
// Optional macro FORWARDING_EN reduces hazard checking to load-use only.
module id_exe_stage
  import id_exe_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              id_is_immediate,
  input  logic              id_MEM_R_EN,
  input  logic              id_MEM_W_EN,
  input  logic              id_WB_EN,
  input  logic [3:0]        id_EXE_CMD,
  input  logic [1:0]        id_br_type,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [DATA_W-1:0] id_st_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_two_src,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              mem_WB_EN,
  output logic              exe_is_immediate,
  output logic              exe_MEM_R_EN,
  output logic              exe_MEM_W_EN,
  output logic              exe_WB_EN,
  output logic [3:0]        exe_EXE_CMD,
  output logic [1:0]        exe_br_type,
  output logic [DATA_W-1:0] exe_val1,
  output logic [DATA_W-1:0] exe_val2,
  output logic [DATA_W-1:0] exe_st_val,
  output logic [DATA_W-1:0] exe_imm,
  output logic [DATA_W-1:0] exe_pc,
  output logic [REG_W-1:0]  exe_src1,
  output logic [REG_W-1:0]  exe_src2,
  output logic [REG_W-1:0]  exe_dest,
  output logic              exe_two_src,
  output logic              hazard_stall,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  ctrl_t             ctrl_id;
  ctrl_t             ctrl_p0;
  logic [DATA_W-1:0] val1_p0, val2_p0, st_val_p0, imm_p0, pc_p0;
  logic [REG_W-1:0]  src1_p0, src2_p0, dest_p0;
  logic              two_src_p0;
  logic              cond_taken;
  logic              hazard_raw;

  assign ctrl_id = '{
    is_immediate: id_is_immediate,
    mem_r_en:     id_MEM_R_EN,
    mem_w_en:     id_MEM_W_EN,
    wb_en:        id_WB_EN,
    exe_cmd:      id_EXE_CMD,
    br_type:      id_br_type
  };

  // ID -> EXE boundary: rst beats freeze, freeze beats bubble insertion.
  always_ff @(posedge clk) begin
    if (rst || (!freeze && (branch_taken || hazard_stall))) begin
      ctrl_p0    <= CTRL_BUBBLE;
      val1_p0    <= '0;
      val2_p0    <= '0;
      st_val_p0  <= '0;
      imm_p0     <= '0;
      pc_p0      <= '0;
      src1_p0    <= '0;
      src2_p0    <= '0;
      dest_p0    <= '0;
      two_src_p0 <= 1'b0;
    end else if (!freeze) begin
      ctrl_p0    <= ctrl_id;
      val1_p0    <= id_val1;
      val2_p0    <= id_val2;
      st_val_p0  <= id_st_val;
      imm_p0     <= id_imm;
      pc_p0      <= id_pc;
      src1_p0    <= id_src1;
      src2_p0    <= id_src2;
      dest_p0    <= id_dest;
      two_src_p0 <= id_two_src;
    end
  end

  always_comb begin
    cond_taken = 1'b0;
    case (ctrl_p0.br_type)
      BR_BEZ:  cond_taken = (val1_p0 == '0);
      BR_BNE:  cond_taken = (val1_p0 != val2_p0);
      BR_JMP:  cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // A frozen pipeline must not redirect the PC.
  assign branch_taken  = cond_taken & ~freeze;
  assign branch_target = pc_p0 + (imm_p0 << 2);

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .src1         (id_src1),
    .src2         (id_src2),
    .check_src2   (id_two_src | id_MEM_W_EN),
    .exe_dest     (dest_p0),
    .exe_wb_en    (ctrl_p0.wb_en),
    .exe_mem_r_en (ctrl_p0.mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_WB_EN),
    .hazard       (hazard_raw)
  );

  // The ID instruction is squashed by a taken branch, so no stall is needed.
  assign hazard_stall = hazard_raw & ~branch_taken;

  assign exe_is_immediate = ctrl_p0.is_immediate;
  assign exe_MEM_R_EN     = ctrl_p0.mem_r_en;
  assign exe_MEM_W_EN     = ctrl_p0.mem_w_en;
  assign exe_WB_EN        = ctrl_p0.wb_en;
  assign exe_EXE_CMD      = ctrl_p0.exe_cmd;
  assign exe_br_type      = ctrl_p0.br_type;
  assign exe_val1         = val1_p0;
  assign exe_val2         = val2_p0;
  assign exe_st_val       = st_val_p0;
  assign exe_imm          = imm_p0;
  assign exe_pc           = pc_p0;
  assign exe_src1         = src1_p0;
  assign exe_src2         = src2_p0;
  assign exe_dest         = dest_p0;
  assign exe_two_src      = two_src_p0;

endmodule
